// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signals seen by the stall/flush controller.
// The pipeline drives hazard inputs (master) and the controller drives stage controls (slave).
interface hazard_stall_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0]             IF_ID_RegRs;
  logic [4:0]             IF_ID_RegRt;
  logic                   IF_ID_UsesRt;
  logic [4:0]             ID_EX_RegRt;
  logic                   ID_EX_MemRead;
  logic                   EX_MEM_MemAccess;
  logic                   DMem_Ready;
  logic                   BranchTaken;
  logic                   PC_Write;
  logic                   IF_ID_Write;
  logic                   ID_EX_Write;
  logic                   EX_MEM_Write;
  logic                   ID_EX_Bubble;
  logic                   MEM_WB_Bubble;
  logic                   IF_ID_Flush;
  logic [STALL_CNT_W-1:0] Stall_Count;
  logic                   Mem_Timeout;

  modport master (
    output IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_RegRt, ID_EX_MemRead,
           EX_MEM_MemAccess, DMem_Ready, BranchTaken,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble,
           MEM_WB_Bubble, IF_ID_Flush, Stall_Count, Mem_Timeout
  );

  modport slave (
    input  IF_ID_RegRs, IF_ID_RegRt, IF_ID_UsesRt, ID_EX_RegRt, ID_EX_MemRead,
           EX_MEM_MemAccess, DMem_Ready, BranchTaken,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, ID_EX_Bubble,
           MEM_WB_Bubble, IF_ID_Flush, Stall_Count, Mem_Timeout
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, data-memory
// wait freezes and taken-branch flushes, plus stall statistics and a wait timeout.
module hazard_stall_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);
  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_LU_STALL = 2'd1;
  localparam logic [1:0]  ST_MEM_WAIT = 2'd2;
  localparam logic [15:0] TIMEOUT_L   = 16'(MEM_TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1  = 16'(MEM_TIMEOUT - 1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [15:0]            r_wait_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_timeout;

  logic w_memwait;
  logic w_lu;
  logic w_lu_stall;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_id_ex_write;
  logic w_ex_mem_write;
  logic w_id_ex_bubble;
  logic w_mem_wb_bubble;
  logic w_if_id_flush;

  assign w_memwait = bus.EX_MEM_MemAccess && !bus.DMem_Ready;
  assign w_lu      = bus.ID_EX_MemRead && (bus.ID_EX_RegRt != 5'd0) &&
                     ((bus.ID_EX_RegRt == bus.IF_ID_RegRs) ||
                      (bus.IF_ID_UsesRt && (bus.ID_EX_RegRt == bus.IF_ID_RegRt)));

  always_comb begin
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_ex_mem_write  = 1'b1;
    w_id_ex_bubble  = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_if_id_flush   = 1'b0;
    w_lu_stall      = 1'b0;
    w_state_next    = ST_RUN;
    // Outputs sit at their reset values for as long as rst_n is held low.
    if (rst_n) begin
      if (w_memwait) begin
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_id_ex_write   = 1'b0;
        w_ex_mem_write  = 1'b0;
        w_mem_wb_bubble = 1'b1;
        w_state_next    = ST_MEM_WAIT;
      end else if (bus.BranchTaken) begin
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if (w_lu && (r_state != ST_LU_STALL)) begin
        // The dependent instruction has already waited one cycle in LU_STALL.
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_id_ex_bubble = 1'b1;
        w_lu_stall     = 1'b1;
        w_state_next   = ST_LU_STALL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= 16'd0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (!w_memwait) begin
        r_wait_cnt <= 16'd0;
      end else if (r_wait_cnt != TIMEOUT_L) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_memwait && (r_wait_cnt >= TIMEOUT_M1)) begin
        r_timeout <= 1'b1;
      end
      if ((w_memwait || w_lu_stall) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.PC_Write      = w_pc_write;
  assign bus.IF_ID_Write   = w_if_id_write;
  assign bus.ID_EX_Write   = w_id_ex_write;
  assign bus.EX_MEM_Write  = w_ex_mem_write;
  assign bus.ID_EX_Bubble  = w_id_ex_bubble;
  assign bus.MEM_WB_Bubble = w_mem_wb_bubble;
  assign bus.IF_ID_Flush   = w_if_id_flush;
  assign bus.Stall_Count   = r_stall_cnt;
  assign bus.Mem_Timeout   = r_timeout;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios followed by random
// traffic, each cycle checked against a rule-level reference model.
module tb_hazard_stall_ctrl;
  localparam int STALL_W   = 6;
  localparam int MEM_TO    = 4;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  typedef struct {
    logic [6:0]         ctl;
    logic [STALL_W-1:0] cnt;
    logic               to;
    string              tag;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  // Reference model state: what happened in earlier cycles, in spec terms.
  bit m_prev_lu;
  int m_stalls;
  int m_wait;
  bit m_to;

  hazard_stall_ctrl_if #(.STALL_CNT_W(STALL_W)) bus ();

  hazard_stall_ctrl #(
    .STALL_CNT_W(STALL_W),
    .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the controller presents a full set of controls every cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Write, bus.EX_MEM_Write,
             bus.ID_EX_Bubble, bus.MEM_WB_Bubble, bus.IF_ID_Flush};
      n_checks++;
      if (act !== e.ctl || bus.Stall_Count !== e.cnt || bus.Mem_Timeout !== e.to) begin
        n_errors++;
        $display("FAIL %s: got ctl=%b cnt=%0d to=%b, expected ctl=%b cnt=%0d to=%b",
                 e.tag, act, bus.Stall_Count, bus.Mem_Timeout, e.ctl, e.cnt, e.to);
      end else begin
        $display("ok   %s: ctl=%b cnt=%0d to=%b", e.tag, act, bus.Stall_Count, bus.Mem_Timeout);
      end
    end
  end

  task automatic cyc(input bit rst, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                     input logic [4:0] exrt, input bit mr, input bit acc, input bit rdy,
                     input bit br, input string tag);
    exp_t e;
    bit   memwait;
    bit   lu;
    bit   lus;
    @(posedge clk);
    #1;
    rst_n                = rst;
    bus.IF_ID_RegRs      = rs;
    bus.IF_ID_RegRt      = rt;
    bus.IF_ID_UsesRt     = urt;
    bus.ID_EX_RegRt      = exrt;
    bus.ID_EX_MemRead    = mr;
    bus.EX_MEM_MemAccess = acc;
    bus.DMem_Ready       = rdy;
    bus.BranchTaken      = br;
    e.tag = tag;
    if (!rst) begin
      e.ctl = 7'b1111000;
      e.cnt = '0;
      e.to  = 1'b0;
      m_prev_lu = 1'b0;
      m_stalls  = 0;
      m_wait    = 0;
      m_to      = 1'b0;
    end else begin
      memwait = acc && !rdy;
      lu      = mr && (exrt != 5'd0) && ((exrt == rs) || (urt && (exrt == rt)));
      lus     = 1'b0;
      e.cnt   = STALL_W'(m_stalls);
      e.to    = m_to;
      if (memwait)                   e.ctl = 7'b0000010;
      else if (br)                   e.ctl = 7'b1111101;
      else if (lu && !m_prev_lu) begin
        e.ctl = 7'b0011100;
        lus   = 1'b1;
      end else                       e.ctl = 7'b1111000;
      m_prev_lu = lus;
      if ((memwait || lus) && m_stalls < STALL_MAX) m_stalls++;
      m_wait = memwait ? m_wait + 1 : 0;
      if (m_wait >= MEM_TO) m_to = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_prev_lu = 1'b0;
    m_stalls  = 0;
    m_wait    = 0;
    m_to      = 1'b0;
    rst_n = 1'b0;
    bus.IF_ID_RegRs = 5'd0; bus.IF_ID_RegRt = 5'd0; bus.IF_ID_UsesRt = 1'b0;
    bus.ID_EX_RegRt = 5'd0; bus.ID_EX_MemRead = 1'b0; bus.EX_MEM_MemAccess = 1'b0;
    bus.DMem_Ready = 1'b1; bus.BranchTaken = 1'b0;

    cyc(1'b0, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, "reset_hold");
    idle("reset_release");

    cyc(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, "loaduse_stall");
    cyc(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, "loaduse_advance");
    idle("loaduse_after");

    cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, "zero_reg_load");
    cyc(1'b1, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, "rt_unused");
    cyc(1'b1, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, "rt_used_stall");
    idle("rt_after");

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, "memwait_freeze");
    cyc(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, "memwait_release");
    idle("memwait_after");

    for (int i = 0; i < 2; i++)
      cyc(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, "branch_frozen");
    cyc(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, "branch_release_flush");
    cyc(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, "branch_vs_loaduse");
    idle("branch_after");

    cyc(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, "wait_then_lu");
    cyc(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, "release_lu_stall");
    cyc(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, "release_lu_advance");

    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_before_timeout");
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, "timeout_wait");
    cyc(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, "reset_mid_wait");
    idle("after_reset");

    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0), "random");
    end
    idle("drain");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall and flush controller for the 5-stage pipeline. It covers the hazards that bypassing cannot resolve: load-use dependencies, multi-cycle data-memory accesses and taken branches.
- The forwarding unit resolves hazards by bypassing operands into EX. This block holds or squashes upstream stages so that bypassing is always sufficient when EX executes.
- It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write-enable, bubble and flush controls.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.
- MEM_TIMEOUT, 64, maximum consecutive memory-wait cycles before Mem_Timeout is raised; legal range 1..2^16-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_ID_RegRs  in  5  rs of the instruction in ID.
- IF_ID_RegRt  in  5  rt of the instruction in ID.
- IF_ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_EX_RegRt  in  5  destination of the instruction in EX when it is a load.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_MemAccess  in  1  instruction in MEM is a load or store.
- DMem_Ready  in  1  data memory completes the access this cycle.
- BranchTaken  in  1  branch resolved taken in EX this cycle.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- ID_EX_Write  out  1  ID/EX load enable.
- EX_MEM_Write  out  1  EX/MEM load enable.
- ID_EX_Bubble  out  1  load a NOP (all control zero) into ID/EX.
- MEM_WB_Bubble  out  1  load a NOP into MEM/WB.
- IF_ID_Flush  out  1  squash IF/ID.
- Stall_Count  out  STALL_CNT_W  total stall cycles, saturating.
- Mem_Timeout  out  1  sticky memory-wait timeout error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=RUN, wait counter=0, Stall_Count=0, Mem_Timeout=0.
  - Write enables forced to 1; Bubble and Flush outputs forced to 0.
- States: RUN, LU_STALL, MEM_WAIT. Outputs are combinational from the current state and inputs, with zero-cycle latency.
- Conditions:
  - memwait = EX_MEM_MemAccess && !DMem_Ready.
  - lu = ID_EX_MemRead && ID_EX_RegRt!=0 && (ID_EX_RegRt==IF_ID_RegRs || (IF_ID_UsesRt && ID_EX_RegRt==IF_ID_RegRt)).
- Priority: memwait > BranchTaken > lu.
- Freeze (memwait true in any state):
  - All four write enables = 0, MEM_WB_Bubble = 1, other outputs = 0.
  - Next state = MEM_WAIT.
- Flush (BranchTaken && !memwait):
  - IF_ID_Flush=1, ID_EX_Bubble=1, all write enables=1.
  - lu is ignored because the dependent instruction is squashed.
  - Next state = RUN.
- Load-use (RUN && lu && !BranchTaken && !memwait):
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; ID_EX_Write and EX_MEM_Write = 1.
  - Next state = LU_STALL.
- LU_STALL:
  - Lasts exactly one cycle; lu is not re-evaluated in this state.
  - Outputs follow normal advance unless memwait or BranchTaken is true.
  - Next state = RUN, or MEM_WAIT if memwait.
- MEM_WAIT:
  - Leaves on the cycle DMem_Ready=1. The release cycle advances normally; a BranchTaken held in frozen EX is applied then.
  - Next state = RUN. If lu is true on the release cycle, the load-use stall is applied that cycle and next state = LU_STALL.
- Wait counter:
  - Increments in each cycle memwait=1; cleared when memwait=0.
  - When it reaches MEM_TIMEOUT, Mem_Timeout is set. Mem_Timeout remains set until reset; the freeze continues.
- Stall_Count:
  - +1 in each cycle with memwait or a load-use stall; flush cycles do not count.
  - Saturates at all-ones.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RegRt=8, IF_ID_RegRs=8 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1. The next cycle is a normal advance. Stall_Count=1.
- $zero load and rt-unused: ID_EX_RegRt=0 -> no stall. Separately, ID_EX_RegRt=9, IF_ID_RegRt=9, IF_ID_UsesRt=0 -> no stall.
- Memory wait: EX_MEM_MemAccess=1 with DMem_Ready low for 3 cycles, then high -> write enables 0 and MEM_WB_Bubble=1 for 3 cycles. Release on the 4th cycle; Stall_Count=3.
- Branch during freeze: BranchTaken=1 with memwait for 2 cycles -> no flush while frozen. IF_ID_Flush=1 and ID_EX_Bubble=1 on the release cycle.
- Branch versus load-use in the same cycle -> flush only, no PC hold, Stall_Count unchanged.
- Timeout and reset: MEM_TIMEOUT=4, DMem_Ready held low -> Mem_Timeout=1 at wait count 4 and remains set. Asserting rst_n=0 mid-wait immediately returns outputs to reset values and state to RUN.
